// File: rtl/sram_pkg.sv
// Shared types and default geometry for the SRAM serial read path.
// Width constants are derived from the default array shape.
package sram_pkg;

  localparam int DEF_ROWS       = 16;
  localparam int DEF_COLS       = 8;
  localparam int DEF_RD_TIMEOUT = 15;

  localparam int ADDR_W   = $clog2(DEF_ROWS);
  localparam int BITCNT_W = $clog2(DEF_COLS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    SHIFT = 2'd2
  } rd_state_e;

endpackage

// File: rtl/sram_serial_reader_piso_shifter.sv
// Parallel-in serial-out shift register, MSB first, zero fill.
// It mirrors the serial-in register on the SRAM write path.
module piso_shifter #(
  parameter int WIDTH = sram_pkg::DEF_COLS
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             msb,
  output logic             last
);

  localparam int BW = $clog2(WIDTH);

  logic [WIDTH-1:0] sreg;
  logic [BW-1:0]    bit_cnt;

  // NOTE: sequential state is updated with <= only, so every register in this
  // block samples the pre-edge values and update order cannot matter.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      sreg    <= load_data;
      bit_cnt <= BW'(WIDTH - 1);
    end else if (shift_en) begin
      sreg    <= {sreg[WIDTH-2:0], 1'b0};
      bit_cnt <= bit_cnt - 1'b1;
    end
  end

  assign msb  = sreg[WIDTH-1];
  assign last = (bit_cnt == '0);

endmodule

// File: rtl/sram_serial_reader.sv
// Reads one SRAM row on request and streams the word out MSB first with a
// valid/ready handshake; aborts with rd_err if the macro never answers.
module sram_serial_reader
  import sram_pkg::*;
#(
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int RD_TIMEOUT = DEF_RD_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    req_valid,
  input  logic [$clog2(ROWS)-1:0] req_addr,
  output logic                    req_ready,
  output logic                    r_en,
  output logic [$clog2(ROWS)-1:0] addr,
  input  logic                    data_valid,
  input  logic [COLS-1:0]         data_out,
  output logic                    ser_out,
  output logic                    ser_valid,
  output logic                    ser_last,
  input  logic                    ser_ready,
  output logic                    rd_err
);

  localparam int AW = $clog2(ROWS);
  localparam int TW = $clog2(RD_TIMEOUT + 1);

  rd_state_e      state_q, state_d;
  logic [AW-1:0]  addr_q;
  logic [TW-1:0]  tmo_q;
  logic           rd_err_q;
  logic           load, shift_en, timeout, last;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    r_en      = 1'b0;
    ser_valid = 1'b0;
    load      = 1'b0;
    shift_en  = 1'b0;
    timeout   = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = READ;
      end
      READ: begin
        r_en = 1'b1;
        // Data arriving on the final allowed cycle still wins over the abort.
        if (data_valid) begin
          load    = 1'b1;
          state_d = SHIFT;
        end else if (tmo_q == TW'(RD_TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      SHIFT: begin
        ser_valid = 1'b1;
        if (ser_ready) begin
          shift_en = 1'b1;
          if (last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      tmo_q    <= '0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_err_q <= timeout;
      if (state_q == IDLE && req_valid) begin
        addr_q <= req_addr;
        tmo_q  <= '0;
      end else if (state_q == READ && !data_valid && tmo_q != TW'(RD_TIMEOUT)) begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

  piso_shifter #(.WIDTH(COLS)) u_piso (
    .clk       (clk),
    .arst_n    (arst_n),
    .load      (load),
    .load_data (data_out),
    .shift_en  (shift_en),
    .msb       (ser_out),
    .last      (last)
  );

  assign addr     = addr_q;
  assign ser_last = ser_valid && last;
  assign rd_err   = rd_err_q;

endmodule
